// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage LEGv8 pipeline: load-use bubbles,
// MEM-resolved branch squashes, data-memory wait freeze and timeout fault.
// Optional performance counters are built only when PIPE_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned WAIT_W   = 8
) (
    input  logic        CLOCK,
    input  logic        RESET_N,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs2,
    input  logic        ex_memRead,
    input  logic [4:0]  ex_write_reg,
    input  logic        mem_branch_taken,
    input  logic        mem_access,
    input  logic        dmem_ready,
    output logic        pc_en,
    output logic        pc_sel,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        dmem_req,
    output logic        mem_timeout,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_timeout_q, mem_timeout_d;
    logic              lu;
    logic              mem_stall;

    assign lu = ex_memRead && (ex_write_reg != 5'd31) &&
                ((ex_write_reg == id_rs1) || (id_uses_rs2 && (ex_write_reg == id_rs2)));

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        mem_stall     = 1'b0;
        pc_en         = 1'b0;
        pc_sel        = 1'b0;
        ifid_en       = 1'b0;
        idex_en       = 1'b0;
        exmem_en      = 1'b0;
        memwb_en      = 1'b0;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        exmem_flush   = 1'b0;
        dmem_req      = 1'b0;

        if (!RESET_N) begin
            // Flush every stage with NOPs while the PC is held.
            ifid_en       = 1'b1;
            idex_en       = 1'b1;
            exmem_en      = 1'b1;
            memwb_en      = 1'b1;
            ifid_flush    = 1'b1;
            idex_flush    = 1'b1;
            exmem_flush   = 1'b1;
            state_d       = RUN;
            wait_cnt_d    = '0;
            mem_timeout_d = 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    dmem_req  = mem_access;
                    mem_stall = mem_access && !dmem_ready;
                    if (mem_stall) begin
                        state_d    = MEM_WAIT;
                        wait_cnt_d = WAIT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    dmem_req  = mem_access;
                    mem_stall = !dmem_ready;
                    if (mem_stall) begin
                        if (wait_cnt_q == WAIT_W'(MAX_WAIT)) begin
                            state_d       = FAULT;
                            mem_timeout_d = 1'b1;
                        end else begin
                            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                        end
                    end else begin
                        state_d    = RUN;
                        wait_cnt_d = '0;
                    end
                end
                FAULT: begin
                    state_d = FAULT;
                end
                default: begin
                    state_d = RUN;
                end
            endcase

            // A completing access (RUN or MEM_WAIT) takes the normal hazard decision.
            if ((state_q != FAULT) && !mem_stall) begin
                if (mem_branch_taken) begin
                    pc_en       = 1'b1;
                    pc_sel      = 1'b1;
                    ifid_en     = 1'b1;
                    idex_en     = 1'b1;
                    exmem_en    = 1'b1;
                    memwb_en    = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                end else if (lu) begin
                    idex_en     = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_en    = 1'b1;
                    memwb_en    = 1'b1;
                end else begin
                    pc_en       = 1'b1;
                    ifid_en     = 1'b1;
                    idex_en     = 1'b1;
                    exmem_en    = 1'b1;
                    memwb_en    = 1'b1;
                end
            end
        end
    end

    always_ff @(negedge CLOCK) begin
        state_q       <= state_d;
        wait_cnt_q    <= wait_cnt_d;
        mem_timeout_q <= mem_timeout_d;
    end

    assign mem_timeout = mem_timeout_q;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_events_q, flush_events_d;

    // pc_sel is high exactly on a taken-branch squash.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        if (!RESET_N) begin
            stall_cycles_d = '0;
            flush_events_d = '0;
        end else begin
            if ((state_q != FAULT) && !pc_en && (stall_cycles_q != '1))
                stall_cycles_d = stall_cycles_q + 32'd1;
            if (pc_sel && (flush_events_q != '1))
                flush_events_d = flush_events_q + 32'd1;
        end
    end

    always_ff @(negedge CLOCK) begin
        stall_cycles_q <= stall_cycles_d;
        flush_events_q <= flush_events_d;
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus
// randomized traffic compared each cycle against a behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned MW = 4;
`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        CLOCK;
    logic        RESET_N;
    logic [4:0]  id_rs1, id_rs2, ex_write_reg;
    logic        id_uses_rs2, ex_memRead, mem_branch_taken, mem_access, dmem_ready;
    logic        pc_en, pc_sel, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, exmem_flush, dmem_req, mem_timeout;
    logic [31:0] stall_cycles, flush_events;

    pipeline_hazard_ctrl #(.MAX_WAIT(MW), .WAIT_W(8)) dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .ex_memRead(ex_memRead), .ex_write_reg(ex_write_reg),
        .mem_branch_taken(mem_branch_taken), .mem_access(mem_access),
        .dmem_ready(dmem_ready),
        .pc_en(pc_en), .pc_sel(pc_sel),
        .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .dmem_req(dmem_req), .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    initial CLOCK = 1'b1;
    always #5 CLOCK = ~CLOCK;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Model state: non-ready cycles of the outstanding access (0 = none pending).
    int          m_nr = 0;
    bit          m_fault = 1'b0;
    bit          m_tmo = 1'b0;
    logic [31:0] m_stalls = '0;
    logic [31:0] m_flushes = '0;

    bit e_pc_en, e_pc_sel, e_ifid_en, e_idex_en, e_exmem_en, e_memwb_en;
    bit e_ifid_fl, e_idex_fl, e_exmem_fl, e_req, hold, hazard;

    always @(posedge CLOCK) begin
        if (chk_en) begin
            hazard = ex_memRead && (ex_write_reg != 5'd31) &&
                     ((ex_write_reg == id_rs1) || (id_uses_rs2 && (ex_write_reg == id_rs2)));
            hold = (m_nr == 0) ? (mem_access && !dmem_ready) : !dmem_ready;
            {e_pc_en, e_pc_sel, e_ifid_en, e_idex_en, e_exmem_en, e_memwb_en} = '0;
            {e_ifid_fl, e_idex_fl, e_exmem_fl, e_req} = '0;
            if (!RESET_N) begin
                {e_ifid_en, e_idex_en, e_exmem_en, e_memwb_en} = 4'b1111;
                {e_ifid_fl, e_idex_fl, e_exmem_fl} = 3'b111;
            end else if (!m_fault) begin
                e_req = mem_access;
                if (!hold) begin
                    if (mem_branch_taken) begin
                        {e_pc_en, e_pc_sel, e_ifid_en, e_idex_en, e_exmem_en, e_memwb_en} = 6'b111111;
                        {e_ifid_fl, e_idex_fl, e_exmem_fl} = 3'b111;
                    end else if (hazard) begin
                        {e_idex_en, e_exmem_en, e_memwb_en, e_idex_fl} = 4'b1111;
                    end else begin
                        {e_pc_en, e_ifid_en, e_idex_en, e_exmem_en, e_memwb_en} = 5'b11111;
                    end
                end
            end
            chk("pc_en", 32'(pc_en), 32'(e_pc_en));
            chk("pc_sel", 32'(pc_sel), 32'(e_pc_sel));
            chk("ifid_en", 32'(ifid_en), 32'(e_ifid_en));
            chk("idex_en", 32'(idex_en), 32'(e_idex_en));
            chk("exmem_en", 32'(exmem_en), 32'(e_exmem_en));
            chk("memwb_en", 32'(memwb_en), 32'(e_memwb_en));
            chk("ifid_flush", 32'(ifid_flush), 32'(e_ifid_fl));
            chk("idex_flush", 32'(idex_flush), 32'(e_idex_fl));
            chk("exmem_flush", 32'(exmem_flush), 32'(e_exmem_fl));
            chk("dmem_req", 32'(dmem_req), 32'(e_req));
            chk("mem_timeout", 32'(mem_timeout), 32'(m_tmo));
            chk("stall_cycles", stall_cycles, PERF ? m_stalls : 32'd0);
            chk("flush_events", flush_events, PERF ? m_flushes : 32'd0);

            if (!RESET_N) begin
                m_nr = 0; m_fault = 1'b0; m_tmo = 1'b0;
                m_stalls = '0; m_flushes = '0;
            end else if (!m_fault) begin
                if (!e_pc_en && (m_stalls != 32'hFFFF_FFFF)) m_stalls = m_stalls + 1;
                if (!hold && mem_branch_taken && (m_flushes != 32'hFFFF_FFFF)) m_flushes = m_flushes + 1;
                if (hold) begin
                    m_nr++;
                    if (m_nr > int'(MW)) begin
                        m_fault = 1'b1; m_tmo = 1'b1; m_nr = 0;
                    end
                end else begin
                    m_nr = 0;
                end
            end
        end
    end

    // Apply one cycle of inputs after the state edge; returns just after the check edge.
    task automatic cyc(input bit r, input logic [4:0] rs1, input logic [4:0] rs2, input bit u2,
                       input bit mrd, input logic [4:0] wr, input bit br, input bit acc, input bit rdy);
        @(negedge CLOCK);
        #1;
        chk_en = 1'b1;
        RESET_N = r; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = u2;
        ex_memRead = mrd; ex_write_reg = wr; mem_branch_taken = br;
        mem_access = acc; dmem_ready = rdy;
        @(posedge CLOCK);
        #1;
    endtask

    task automatic idle();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rst();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        RESET_N = 1'b0; id_rs1 = '0; id_rs2 = '0; id_uses_rs2 = 1'b0;
        ex_memRead = 1'b0; ex_write_reg = '0; mem_branch_taken = 1'b0;
        mem_access = 1'b0; dmem_ready = 1'b0;

        rst(); rst();
        chk("rst_ifid_en", 32'(ifid_en), 32'd1);
        chk("rst_exmem_flush", 32'(exmem_flush), 32'd1);
        chk("rst_pc_en", 32'(pc_en), 32'd0);
        chk("rst_timeout", 32'(mem_timeout), 32'd0);
        chk("rst_stalls", stall_cycles, 32'd0);

        idle();
        cyc(1, 5, 0, 0, 1, 5, 0, 0, 0);
        chk("lu_pc_en", 32'(pc_en), 32'd0);
        chk("lu_ifid_en", 32'(ifid_en), 32'd0);
        chk("lu_idex_flush", 32'(idex_flush), 32'd1);
        idle();
        chk("lu_after_pc_en", 32'(pc_en), 32'd1);
        cyc(1, 31, 0, 0, 1, 31, 0, 0, 0);
        chk("xzr_pc_en", 32'(pc_en), 32'd1);
        cyc(1, 3, 7, 1, 1, 7, 0, 0, 0);
        chk("lu_rs2_pc_en", 32'(pc_en), 32'd0);
        cyc(1, 3, 7, 0, 1, 7, 0, 0, 0);
        chk("no_rs2_pc_en", 32'(pc_en), 32'd1);

        rst();
        cyc(1, 5, 0, 0, 1, 5, 1, 0, 0);
        chk("br_pc_sel", 32'(pc_sel), 32'd1);
        chk("br_pc_en", 32'(pc_en), 32'd1);
        chk("br_flushes", {29'd0, ifid_flush, idex_flush, exmem_flush}, 32'd7);
        idle();
        chk("br_flush_events", flush_events, PERF ? 32'd1 : 32'd0);
        chk("model_flushes", m_flushes, 32'd1);

        rst();
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
            chk("wait_pc_en", 32'(pc_en), 32'd0);
            chk("wait_memwb_en", 32'(memwb_en), 32'd0);
            chk("wait_req", 32'(dmem_req), 32'd1);
        end
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 1);
        chk("wait_done_pc_en", 32'(pc_en), 32'd1);
        idle();
        chk("wait_stalls", stall_cycles, PERF ? 32'd3 : 32'd0);
        chk("model_stalls", m_stalls, 32'd3);

        cyc(1, 0, 0, 0, 0, 0, 0, 1, 1);
        chk("zero_wait_pc_en", 32'(pc_en), 32'd1);

        for (int i = 0; i < int'(MW); i++) cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 1);
        chk("edge_done_pc_en", 32'(pc_en), 32'd1);
        idle();
        chk("edge_timeout", 32'(mem_timeout), 32'd0);

        for (int i = 0; i < int'(MW) + 1; i++) cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("pre_fault_timeout", 32'(mem_timeout), 32'd0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 1);
        chk("fault_timeout", 32'(mem_timeout), 32'd1);
        chk("fault_req", 32'(dmem_req), 32'd0);
        chk("fault_pc_en", 32'(pc_en), 32'd0);
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("fault_hold", 32'(mem_timeout), 32'd1);
        rst();
        chk("fault_rst_flush", 32'(ifid_flush), 32'd1);
        idle();
        chk("post_rst_timeout", 32'(mem_timeout), 32'd0);
        chk("post_rst_pc_en", 32'(pc_en), 32'd1);

        for (int i = 0; i < 3000; i++) begin
            logic [4:0] a, b, w;
            a = 5'($urandom_range(0, 7));
            b = 5'($urandom_range(0, 7));
            w = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            cyc(($urandom_range(0, 39) != 0), a, b, 1'($urandom), 1'($urandom), w,
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 9) < 6));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
